// File: rtl/gshare_branch_predictor.sv
// rtl/gshare_branch_predictor.sv - gshare/bimodal branch predictor with speculative GHR and recovery
// Define GSHARE_XOR_EN for PC-xor-history indexing; otherwise the table is indexed by PC alone.
module gshare_branch_predictor #(
  parameter int IDX_W  = 4,
  parameter int CTR_W  = 2,
  parameter int HIST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lkp_en,
  input  logic [IDX_W-1:0]  lkp_pc,
  output logic              pre_valid,
  output logic              pre_taken,
  output logic [HIST_W-1:0] pre_ghr,
  input  logic              upd_en,
  input  logic [IDX_W-1:0]  upd_pc,
  input  logic [HIST_W-1:0] upd_ghr,
  input  logic              real_br_taken,
  input  logic              mispredict
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_MIN  = '0;

  logic [CTR_W-1:0]  pht [DEPTH];
  logic [HIST_W-1:0] ghr;

  logic [IDX_W-1:0]  lkp_idx;
  logic [IDX_W-1:0]  upd_idx;
  logic              lkp_taken;
  logic [CTR_W-1:0]  upd_cur;
  logic [CTR_W-1:0]  upd_ctr;
  logic [HIST_W-1:0] ghr_spec;
  logic [HIST_W-1:0] ghr_rec;

`ifdef GSHARE_XOR_EN
  logic [IDX_W-1:0] ghr_ext;
  logic [IDX_W-1:0] upd_ghr_ext;

  // History is zero-extended so HIST_W may be narrower than the index.
  always_comb begin
    ghr_ext                     = '0;
    upd_ghr_ext                 = '0;
    ghr_ext[HIST_W-1:0]         = ghr;
    upd_ghr_ext[HIST_W-1:0]     = upd_ghr;
    lkp_idx                     = lkp_pc ^ ghr_ext;
    upd_idx                     = upd_pc ^ upd_ghr_ext;
  end
`else
  always_comb begin
    lkp_idx = lkp_pc;
    upd_idx = upd_pc;
  end
`endif

  always_comb begin
    lkp_taken = pht[lkp_idx][CTR_W-1];
    upd_cur   = pht[upd_idx];
    upd_ctr   = upd_cur;
    if (real_br_taken && (upd_cur != CTR_MAX)) begin
      upd_ctr = upd_cur + CTR_W'(1);
    end else if (!real_br_taken && (upd_cur != CTR_MIN)) begin
      upd_ctr = upd_cur - CTR_W'(1);
    end
    ghr_spec = HIST_W'({ghr, lkp_taken});
    ghr_rec  = HIST_W'({upd_ghr, real_br_taken});
  end

  // Lookup reads the pre-update table, so a same-cycle update to the same index is seen next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pht[i] <= CTR_INIT;
      end
      ghr       <= '0;
      pre_valid <= 1'b0;
      pre_taken <= 1'b0;
      pre_ghr   <= '0;
    end else begin
      pre_valid <= lkp_en;
      if (lkp_en) begin
        pre_taken <= lkp_taken;
        pre_ghr   <= ghr;
      end
      if (upd_en) begin
        pht[upd_idx] <= upd_ctr;
      end
      // Recovery wins over the speculative shift of a lookup the pipe is about to flush.
      if (upd_en && mispredict) begin
        ghr <= ghr_rec;
      end else if (lkp_en) begin
        ghr <= ghr_spec;
      end
    end
  end

endmodule
